execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the five-stage RV32I pipeline: the decode/execute pipeline register, a combinational ALU with two-source operand forwarding, and the execute/memory pipeline register. It sits between the decoder/register file and the data cache/write-back stage. It exports the live ALU result to the branch unit and register addresses to the hazard and forwarding units.

## Interface
Parameters:
- XLEN, 32, data and immediate width
- REG_AW, 5, register address width
- OP_W, 5, ALU control width
- DCC_W, 3, data-cache control width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears both pipeline registers
- dataReg1, dataReg2  in  XLEN  rs1/rs2 values from the register file
- opCodeFromDec  in  7  instruction opcode
- writeBackAddrIn, dataS1AddrIn, dataS2AddrIn  in  REG_AW  rd, rs1, rs2
- ALUop  in  OP_W  ALU control from the control unit
- immValueIn  in  XLEN  sign-extended immediate
- dataCacheControlIn  in  DCC_W  memory operation code, 0 = none
- writeEnableReg  in  1  instruction writes rd
- CSLToALUMEMIn  in  1  memory-stage data-select flag from the hazard unit
- locker  in  1  stall; the decode/execute register loads a bubble
- select1, select2  in  2  forwarding selects from the forwarding unit
- regDataFromMEM_WB  in  XLEN  write-back data for forwarding
- aluResult  out  XLEN  combinational ALU result
- writeBackAddrEx, opCodeToHazard, dataS1AddrOut, dataS2AddrOut  out  rd, opcode and rs addresses held in the decode/execute register
- dataOut, dataRs2Out  out  XLEN  registered ALU result and store data
- dataCacheControlOut  out  DCC_W
- writeEnableOut, CSLToDataCacheOut  out  1
- writeBackAddrOut  out  REG_AW

## Operation
- Decode/execute register: on each edge, captures all decode inputs.
  - If locker=1, it captures a bubble instead: all fields 0, so writeEnable=0, dataCacheControl=0 and rd=0.
- Operand forwarding, per source: select 00 = registered register-file value; 01 = dataOut (execute/memory register); 10 = regDataFromMEM_WB; 11 = register-file value.
- Operand B = immediate when ALUop[4]=1, otherwise the forwarded rs2.
- ALU functions, selected by ALUop[3:0]:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 PASSB, used for LUI
  - 11–15 produce 0
- ALU arithmetic and comparison rules:
  - Shifts use B[4:0].
  - SLT is signed; SLTU is unsigned.
  - Results are 0 or 1 zero-extended; overflow wraps modulo 2^32.
- Store data: dataRs2Out carries the forwarded rs2, not the raw register value.
- Execute/memory register: captures the ALU result, store data, dataCacheControl, writeEnable, rd and the CSL flag every edge. It has no stall input.

## Timing
- Reset asynchronously clears every registered output to 0.
- Inputs sampled at edge N drive aluResult combinationally after N. They appear on the execute/memory outputs after edge N+1, so latency is 2 edges.
- Back-to-back dependent instructions forward with zero bubbles via select=01. An instruction two ahead forwards via select=10.
- With locker high for k cycles, k bubbles are inserted. The execute/memory register keeps draining.
- When reset is asserted mid-stream, all in-flight instructions are discarded. The first capture after deassertion is the current inputs.
- rd=0 is passed through unchanged; the register file ignores writes to x0.

## Structure
- Package exec_pkg holds:
  - XLEN, REG_AW, OP_W and DCC_W
  - ALU function codes and the immediate flag bit
  - forwarding select codes
  - the DCC_NONE constant
- One sub-module, exec_alu: a combinational operand mux plus function unit.
- The two pipeline registers are inline in execute_stage.

## Test plan
- Reset: assert reset mid-cycle → all registered outputs 0 immediately. Deassert with ADD inputs 5+7 → dataOut=12 two edges later.
- Ops sweep with A=0xFFFFFFF0, B=4:
  - SUB=0xFFFFFFEC
  - SRA=0xFFFFFFFF, SRL=0x0FFFFFFF
  - SLT=1, SLTU=0
  - immediate ADDI with imm=-1 → 0xFFFFFFEF
- Forwarding: ADD x1=3+4, then ADD x2=x1+x1 with select1=select2=01 → 14. Repeat with select=10 and regDataFromMEM_WB=9 → 18.
- Stall: locker=1 for one edge with a store pending → a bubble appears (writeEnableOut=0, dataCacheControlOut=0). The following instruction proceeds normally.
- Store data: dataCacheControlIn≠0, select2=01, prior result 0xDEADBEEF → dataRs2Out=0xDEADBEEF.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared constants for the RV32I execute stage: widths, ALU function codes,
// forwarding select codes and the "no memory operation" cache control value.
package exec_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 5;
  localparam int DCC_W  = 3;

  // ALUop[3:0] selects the function; ALUop[4] swaps operand B for the immediate.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } aluFunc_t;

  localparam int ALU_IMM_BIT = 4;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_EXMEM   = 2'b01,
    FWD_MEMWB   = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwdSel_t;

  localparam logic [DCC_W-1:0] DCC_NONE = '0;

endpackage

// File: rtl/exec_alu.sv
// Combinational operand forwarding mux and RV32I integer function unit.
// Also exports the forwarded rs2 so stores write the freshest value.
module exec_alu #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] aluOp,
  input  logic [XLEN-1:0] rs1Val,
  input  logic [XLEN-1:0] rs2Val,
  input  logic [XLEN-1:0] immVal,
  input  logic [1:0]      select1,
  input  logic [1:0]      select2,
  input  logic [XLEN-1:0] exMemData,
  input  logic [XLEN-1:0] memWbData,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] fwdRs2
);
  import exec_pkg::*;

  localparam int SH_W = $clog2(XLEN);

  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [XLEN-1:0] fwdB;
  logic [SH_W-1:0] shamt;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    opA    = rs1Val;
    fwdB   = rs2Val;
    result = '0;

    case (select1)
      FWD_EXMEM: opA = exMemData;
      FWD_MEMWB: opA = memWbData;
      default:   opA = rs1Val;
    endcase

    case (select2)
      FWD_EXMEM: fwdB = exMemData;
      FWD_MEMWB: fwdB = memWbData;
      default:   fwdB = rs2Val;
    endcase

    opB   = aluOp[ALU_IMM_BIT] ? immVal : fwdB;
    shamt = opB[SH_W-1:0];

    case (aluOp[3:0])
      ALU_ADD:   result = opA + opB;
      ALU_SUB:   result = opA - opB;
      ALU_SLL:   result = opA << shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (opA < opB)};
      ALU_XOR:   result = opA ^ opB;
      ALU_SRL:   result = opA >> shamt;
      ALU_SRA:   result = $unsigned($signed(opA) >>> shamt);
      ALU_OR:    result = opA | opB;
      ALU_AND:   result = opA & opB;
      ALU_PASSB: result = opB;
      default:   result = '0;
    endcase
  end

  assign fwdRs2 = fwdB;

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: decode/execute register (bubble on stall), forwarding
// ALU, and the free-running execute/memory register feeding the data cache.
module execute_stage #(
  parameter int XLEN   = exec_pkg::XLEN,
  parameter int REG_AW = exec_pkg::REG_AW,
  parameter int OP_W   = exec_pkg::OP_W,
  parameter int DCC_W  = exec_pkg::DCC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   dataReg1,
  input  logic [XLEN-1:0]   dataReg2,
  input  logic [6:0]        opCodeFromDec,
  input  logic [REG_AW-1:0] writeBackAddrIn,
  input  logic [REG_AW-1:0] dataS1AddrIn,
  input  logic [REG_AW-1:0] dataS2AddrIn,
  input  logic [OP_W-1:0]   ALUop,
  input  logic [XLEN-1:0]   immValueIn,
  input  logic [DCC_W-1:0]  dataCacheControlIn,
  input  logic              writeEnableReg,
  input  logic              CSLToALUMEMIn,
  input  logic              locker,
  input  logic [1:0]        select1,
  input  logic [1:0]        select2,
  input  logic [XLEN-1:0]   regDataFromMEM_WB,
  output logic [XLEN-1:0]   aluResult,
  output logic [REG_AW-1:0] writeBackAddrEx,
  output logic [6:0]        opCodeToHazard,
  output logic [REG_AW-1:0] dataS1AddrOut,
  output logic [REG_AW-1:0] dataS2AddrOut,
  output logic [XLEN-1:0]   dataOut,
  output logic [XLEN-1:0]   dataRs2Out,
  output logic [DCC_W-1:0]  dataCacheControlOut,
  output logic              writeEnableOut,
  output logic              CSLToDataCacheOut,
  output logic [REG_AW-1:0] writeBackAddrOut
);
  import exec_pkg::*;

  logic [XLEN-1:0]  idExRs1Val;
  logic [XLEN-1:0]  idExRs2Val;
  logic [XLEN-1:0]  idExImm;
  logic [OP_W-1:0]  idExAluOp;
  logic [DCC_W-1:0] idExDcc;
  logic             idExWe;
  logic             idExCsl;
  logic [XLEN-1:0]  fwdRs2;

  // Decode/execute register; a stall loads an all-zero bubble (no write, no memory op, rd=x0).
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      idExRs1Val      <= '0;
      idExRs2Val      <= '0;
      idExImm         <= '0;
      idExAluOp       <= '0;
      idExDcc         <= DCC_NONE;
      idExWe          <= 1'b0;
      idExCsl         <= 1'b0;
      opCodeToHazard  <= '0;
      writeBackAddrEx <= '0;
      dataS1AddrOut   <= '0;
      dataS2AddrOut   <= '0;
    end else if (locker) begin
      idExRs1Val      <= '0;
      idExRs2Val      <= '0;
      idExImm         <= '0;
      idExAluOp       <= '0;
      idExDcc         <= DCC_NONE;
      idExWe          <= 1'b0;
      idExCsl         <= 1'b0;
      opCodeToHazard  <= '0;
      writeBackAddrEx <= '0;
      dataS1AddrOut   <= '0;
      dataS2AddrOut   <= '0;
    end else begin
      idExRs1Val      <= dataReg1;
      idExRs2Val      <= dataReg2;
      idExImm         <= immValueIn;
      idExAluOp       <= ALUop;
      idExDcc         <= dataCacheControlIn;
      idExWe          <= writeEnableReg;
      idExCsl         <= CSLToALUMEMIn;
      opCodeToHazard  <= opCodeFromDec;
      writeBackAddrEx <= writeBackAddrIn;
      dataS1AddrOut   <= dataS1AddrIn;
      dataS2AddrOut   <= dataS2AddrIn;
    end
  end

  exec_alu #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_alu (
    .aluOp     (idExAluOp),
    .rs1Val    (idExRs1Val),
    .rs2Val    (idExRs2Val),
    .immVal    (idExImm),
    .select1   (select1),
    .select2   (select2),
    .exMemData (dataOut),
    .memWbData (regDataFromMEM_WB),
    .result    (aluResult),
    .fwdRs2    (fwdRs2)
  );

  // Execute/memory register has no stall: it drains whatever sits in execute each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut             <= '0;
      dataRs2Out          <= '0;
      dataCacheControlOut <= DCC_NONE;
      writeEnableOut      <= 1'b0;
      CSLToDataCacheOut   <= 1'b0;
      writeBackAddrOut    <= '0;
    end else begin
      dataOut             <= aluResult;
      dataRs2Out          <= fwdRs2;
      dataCacheControlOut <= idExDcc;
      writeEnableOut      <= idExWe;
      CSLToDataCacheOut   <= idExCsl;
      writeBackAddrOut    <= writeBackAddrEx;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: reset, ALU sweep, forwarding,
// stall bubbles and store-data forwarding, with hand-computed expectations.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataReg1, dataReg2, immValueIn, regDataFromMEM_WB;
  logic [6:0]  opCodeFromDec;
  logic [4:0]  writeBackAddrIn, dataS1AddrIn, dataS2AddrIn, ALUop;
  logic [2:0]  dataCacheControlIn;
  logic        writeEnableReg, CSLToALUMEMIn, locker;
  logic [1:0]  select1, select2;
  logic [31:0] aluResult, dataOut, dataRs2Out;
  logic [4:0]  writeBackAddrEx, dataS1AddrOut, dataS2AddrOut, writeBackAddrOut;
  logic [6:0]  opCodeToHazard;
  logic [2:0]  dataCacheControlOut;
  logic        writeEnableOut, CSLToDataCacheOut;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .dataReg1            (dataReg1),
    .dataReg2            (dataReg2),
    .opCodeFromDec       (opCodeFromDec),
    .writeBackAddrIn     (writeBackAddrIn),
    .dataS1AddrIn        (dataS1AddrIn),
    .dataS2AddrIn        (dataS2AddrIn),
    .ALUop               (ALUop),
    .immValueIn          (immValueIn),
    .dataCacheControlIn  (dataCacheControlIn),
    .writeEnableReg      (writeEnableReg),
    .CSLToALUMEMIn       (CSLToALUMEMIn),
    .locker              (locker),
    .select1             (select1),
    .select2             (select2),
    .regDataFromMEM_WB   (regDataFromMEM_WB),
    .aluResult           (aluResult),
    .writeBackAddrEx     (writeBackAddrEx),
    .opCodeToHazard      (opCodeToHazard),
    .dataS1AddrOut       (dataS1AddrOut),
    .dataS2AddrOut       (dataS2AddrOut),
    .dataOut             (dataOut),
    .dataRs2Out          (dataRs2Out),
    .dataCacheControlOut (dataCacheControlOut),
    .writeEnableOut      (writeEnableOut),
    .CSLToDataCacheOut   (CSLToDataCacheOut),
    .writeBackAddrOut    (writeBackAddrOut)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    dataReg1 = '0; dataReg2 = '0; immValueIn = '0; regDataFromMEM_WB = '0;
    opCodeFromDec = '0; writeBackAddrIn = '0; dataS1AddrIn = '0; dataS2AddrIn = '0;
    ALUop = '0; dataCacheControlIn = '0; writeEnableReg = 1'b0;
    CSLToALUMEMIn = 1'b0; locker = 1'b0; select1 = 2'b00; select2 = 2'b00;
  endtask

  task automatic setInstr(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] op, input logic [4:0] rd,
                          input logic [2:0] dcc, input logic we);
    dataReg1 = a; dataReg2 = b; immValueIn = imm; ALUop = op;
    writeBackAddrIn = rd; dataCacheControlIn = dcc; writeEnableReg = we;
    opCodeFromDec = 7'h33; dataS1AddrIn = 5'd1; dataS2AddrIn = 5'd2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clearIn();
    #3;
    total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL reset_dataOut got=%h want=0", dataOut); end
    total++; if (writeBackAddrEx !== 5'h0) begin bad++; $display("FAIL reset_rdEx got=%h want=0", writeBackAddrEx); end
    @(negedge clk) reset = 1'b0;
    setInstr(32'd10, 32'd20, 32'd0, 5'd0, 5'd5, 3'd0, 1'b1);
    tick(); tick();
    total++; if (dataOut !== 32'd30 || writeEnableOut !== 1'b1) begin
      bad++; $display("FAIL preload got=%0d/%b want=30/1", dataOut, writeEnableOut); end
    #2 reset = 1'b1;
    #1;
    total++; if (dataOut !== 32'h0 || writeEnableOut !== 1'b0 || writeBackAddrOut !== 5'h0) begin
      bad++; $display("FAIL midreset_exmem got=%h/%b/%h want=0/0/0", dataOut, writeEnableOut, writeBackAddrOut); end
    total++; if (writeBackAddrEx !== 5'h0 || opCodeToHazard !== 7'h0 || aluResult !== 32'h0) begin
      bad++; $display("FAIL midreset_idex got=%h/%h/%h want=0/0/0", writeBackAddrEx, opCodeToHazard, aluResult); end
    setInstr(32'd5, 32'd7, 32'd0, 5'd0, 5'd6, 3'd0, 1'b1);
    @(negedge clk) reset = 1'b0;
    tick();
    total++; if (aluResult !== 32'd12 || dataOut !== 32'd0) begin
      bad++; $display("FAIL reset_edge1 got=%0d/%0d want=12/0", aluResult, dataOut); end
    tick();
    total++; if (dataOut !== 32'd12 || writeBackAddrOut !== 5'd6) begin
      bad++; $display("FAIL reset_edge2 got=%0d/%0d want=12/6", dataOut, writeBackAddrOut); end
  endtask

  task automatic test_ops();
    logic [4:0]  opT  [14];
    logic [31:0] expT [14];
    opT[0]  = 5'd1;  expT[0]  = 32'hFFFFFFEC;
    opT[1]  = 5'd2;  expT[1]  = 32'hFFFFFF00;
    opT[2]  = 5'd3;  expT[2]  = 32'h00000001;
    opT[3]  = 5'd4;  expT[3]  = 32'h00000000;
    opT[4]  = 5'd5;  expT[4]  = 32'hFFFFFFF4;
    opT[5]  = 5'd6;  expT[5]  = 32'h0FFFFFFF;
    opT[6]  = 5'd7;  expT[6]  = 32'hFFFFFFFF;
    opT[7]  = 5'd8;  expT[7]  = 32'hFFFFFFF4;
    opT[8]  = 5'd9;  expT[8]  = 32'h00000000;
    opT[9]  = 5'd10; expT[9]  = 32'h00000004;
    opT[10] = 5'd13; expT[10] = 32'h00000000;
    opT[11] = 5'h10; expT[11] = 32'hFFFFFFEF;
    opT[12] = 5'd0;  expT[12] = 32'hFFFFFFF4;
    opT[13] = 5'h1A; expT[13] = 32'hFFFFFFFF;
    clearIn();
    for (int i = 0; i < 14; i++) begin
      setInstr(32'hFFFFFFF0, 32'd4, 32'hFFFFFFFF, opT[i], 5'd7, 3'd0, 1'b1);
      tick();
      total++; if (aluResult !== expT[i]) begin
        bad++; $display("FAIL op_%0h got=%h want=%h", opT[i], aluResult, expT[i]); end
    end
    tick();
    total++; if (dataOut !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL op_registered got=%h want=ffffffff", dataOut); end
    setInstr(32'h1, 32'h24, 32'h0, 5'd2, 5'd7, 3'd0, 1'b1);
    tick();
    total++; if (aluResult !== 32'h10) begin
      bad++; $display("FAIL sll_shamt5 got=%h want=00000010", aluResult); end
    setInstr(32'hFFFFFFFF, 32'h1, 32'h0, 5'd0, 5'd7, 3'd0, 1'b1);
    tick();
    total++; if (aluResult !== 32'h0) begin
      bad++; $display("FAIL add_wrap got=%h want=0", aluResult); end
  endtask

  task automatic test_forward();
    clearIn();
    setInstr(32'd3, 32'd4, 32'd0, 5'd0, 5'd1, 3'd0, 1'b1);
    tick();
    setInstr(32'hAAAA, 32'hBBBB, 32'd0, 5'd0, 5'd2, 3'd0, 1'b1);
    tick();
    select1 = 2'b01; select2 = 2'b01;
    #1;
    total++; if (aluResult !== 32'd14) begin
      bad++; $display("FAIL fwd_exmem got=%0d want=14", aluResult); end
    regDataFromMEM_WB = 32'd9;
    select1 = 2'b01; select2 = 2'b10;
    #1;
    total++; if (aluResult !== 32'd16) begin
      bad++; $display("FAIL fwd_mixed got=%0d want=16", aluResult); end
    select1 = 2'b11; select2 = 2'b11;
    #1;
    total++; if (aluResult !== 32'h16665) begin
      bad++; $display("FAIL fwd_sel11 got=%h want=00016665", aluResult); end
    select1 = 2'b01; select2 = 2'b01;
    tick();
    total++; if (dataOut !== 32'd14) begin
      bad++; $display("FAIL fwd_dataOut got=%0d want=14", dataOut); end
    select1 = 2'b00; select2 = 2'b00;
    setInstr(32'd3, 32'd4, 32'd0, 5'd0, 5'd1, 3'd0, 1'b1);
    tick();
    setInstr(32'hAAAA, 32'hBBBB, 32'd0, 5'd0, 5'd2, 3'd0, 1'b1);
    tick();
    regDataFromMEM_WB = 32'd9;
    select1 = 2'b10; select2 = 2'b10;
    #1;
    total++; if (aluResult !== 32'd18) begin
      bad++; $display("FAIL fwd_memwb got=%0d want=18", aluResult); end
  endtask

  task automatic test_stall();
    clearIn();
    setInstr(32'd1, 32'd2, 32'd0, 5'd0, 5'd3, 3'd0, 1'b1);
    tick();
    setInstr(32'h100, 32'h55, 32'd8, 5'h10, 5'd0, 3'd2, 1'b0);
    locker = 1'b1;
    tick();
    total++; if (writeBackAddrEx !== 5'd0 || aluResult !== 32'd0 || opCodeToHazard !== 7'd0) begin
      bad++; $display("FAIL stall_idex got=%h/%h/%h want=0/0/0", writeBackAddrEx, aluResult, opCodeToHazard); end
    total++; if (writeEnableOut !== 1'b1 || writeBackAddrOut !== 5'd3 || dataOut !== 32'd3) begin
      bad++; $display("FAIL stall_drain got=%b/%0d/%0d want=1/3/3", writeEnableOut, writeBackAddrOut, dataOut); end
    locker = 1'b0;
    tick();
    total++; if (writeEnableOut !== 1'b0 || dataCacheControlOut !== 3'd0 || writeBackAddrOut !== 5'd0) begin
      bad++; $display("FAIL stall_bubble got=%b/%0d/%0d want=0/0/0", writeEnableOut, dataCacheControlOut, writeBackAddrOut); end
    total++; if (aluResult !== 32'h108) begin
      bad++; $display("FAIL stall_resume_alu got=%h want=00000108", aluResult); end
    tick();
    total++; if (dataCacheControlOut !== 3'd2 || dataOut !== 32'h108 || dataRs2Out !== 32'h55) begin
      bad++; $display("FAIL stall_resume_mem got=%0d/%h/%h want=2/108/55", dataCacheControlOut, dataOut, dataRs2Out); end
  endtask

  task automatic test_store_data();
    clearIn();
    setInstr(32'hDEADBEEF, 32'd0, 32'd0, 5'd0, 5'd4, 3'd0, 1'b1);
    tick();
    setInstr(32'h200, 32'h11111111, 32'd4, 5'h10, 5'd0, 3'd2, 1'b0);
    CSLToALUMEMIn = 1'b1;
    tick();
    select2 = 2'b01;
    #1;
    total++; if (aluResult !== 32'h204) begin
      bad++; $display("FAIL store_addr got=%h want=00000204", aluResult); end
    tick();
    total++; if (dataRs2Out !== 32'hDEADBEEF || dataCacheControlOut !== 3'd2) begin
      bad++; $display("FAIL store_data got=%h/%0d want=deadbeef/2", dataRs2Out, dataCacheControlOut); end
    total++; if (dataOut !== 32'h204 || CSLToDataCacheOut !== 1'b1 || writeEnableOut !== 1'b0) begin
      bad++; $display("FAIL store_ctrl got=%h/%b/%b want=204/1/0", dataOut, CSLToDataCacheOut, writeEnableOut); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_forward();
    test_stall();
    test_store_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
